// File: rtl/mandelbrot_lane_dispatcher.sv
// Raster-order frame scheduler: dispatches pixel batches to LANES point generators and streams
// captured iteration counts through a registered FIFO. Define MANDEL_DISPATCH_STATS_EN for stat_cycles.
module mandelbrot_lane_dispatcher #(
    parameter int LANES      = 4,
    parameter int IW         = 16,
    parameter int XW         = 11,
    parameter int YW         = 11,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                frame_start,
    input  logic                frame_abort,
    input  logic [XW-1:0]       x_size,
    input  logic [YW-1:0]       y_size,
    output logic                busy,
    output logic                gen_start,
    output logic [LANES*XW-1:0] gen_x,
    output logic [LANES*YW-1:0] gen_y,
    output logic [LANES-1:0]    gen_valid,
    input  logic [LANES-1:0]    gen_done,
    input  logic [LANES*IW-1:0] gen_iter,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IW-1:0]       out_data,
    output logic [XW-1:0]       out_x,
    output logic [YW-1:0]       out_y,
    output logic                out_last,
    output logic                frame_done,
    output logic [31:0]         stat_cycles,
    output logic [1:0]          dbg_state
);
    // out_valid/out_ready: a word transfers on a rising edge where both are high; while
    // out_valid && !out_ready the word and its sidebands (out_x, out_y, out_last) hold.

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = 1 + YW + XW + IW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [XW-1:0]    xs_q;
    logic [YW-1:0]    ys_q;
    logic [XW-1:0]    lane_x     [LANES];
    logic [YW-1:0]    lane_y     [LANES];
    logic [XW:0]      lane_sum   [LANES];
    logic [XW-1:0]    lane_x_nxt [LANES];
    logic [YW-1:0]    lane_y_nxt [LANES];
    logic [LANES-1:0] lane_vld, lane_ok;

    logic [IW-1:0]    bank_data [LANES];
    logic [XW-1:0]    bank_x    [LANES];
    logic [YW-1:0]    bank_y    [LANES];
    logic [LANES-1:0] bank_vld;

    logic start_accept, capture, last_batch, bank_empty;
    logic sel_found, push, pop, fifo_full, fifo_empty;
    logic [LW-1:0] sel_idx;
    logic [FW-1:0] push_word, head;
    logic [FW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    always_comb begin
        gen_x = '0;
        gen_y = '0;
        for (int i = 0; i < LANES; i++) begin
            // One subtraction suffices for the wrap because LANES never exceeds the frame width.
            lane_sum[i] = {1'b0, lane_x[i]} + (XW+1)'(LANES);
            if (lane_sum[i] >= {1'b0, xs_q}) begin
                lane_x_nxt[i] = XW'(lane_sum[i] - {1'b0, xs_q});
                lane_y_nxt[i] = lane_y[i] + YW'(1);
            end else begin
                lane_x_nxt[i] = lane_sum[i][XW-1:0];
                lane_y_nxt[i] = lane_y[i];
            end
            lane_vld[i] = (state != IDLE) && (lane_y[i] < ys_q);
            lane_ok[i]  = gen_done[i] | ~lane_vld[i];
            gen_x[i*XW +: XW] = lane_x[i];
            gen_y[i*YW +: YW] = lane_y[i];
        end
    end

    assign gen_valid    = lane_vld;
    assign bank_empty   = ~|bank_vld;
    assign start_accept = (state == IDLE) && frame_start && !frame_abort;
    assign capture      = (state == WAIT) && (&lane_ok) && bank_empty;
    // Lane 0 holds the earliest pixel, so once it steps past the frame the batch just done held the last one.
    assign last_batch   = lane_y_nxt[0] >= ys_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_accept) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (capture) state_nxt = last_batch ? FLUSH : LAUNCH;
            FLUSH:   if (bank_empty && fifo_empty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (frame_abort) state_nxt = IDLE;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign busy      = (state != IDLE);
    assign gen_start = (state == LAUNCH);
    assign dbg_state = state;

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            xs_q     <= '0;
            ys_q     <= '0;
            bank_vld <= '0;
            for (int i = 0; i < LANES; i++) begin
                lane_x[i]    <= '0;
                lane_y[i]    <= '0;
                bank_data[i] <= '0;
                bank_x[i]    <= '0;
                bank_y[i]    <= '0;
            end
        end else if (frame_abort) begin
            bank_vld <= '0;
        end else begin
            if (start_accept) begin
                xs_q <= x_size;
                ys_q <= y_size;
                for (int i = 0; i < LANES; i++) begin
                    lane_x[i] <= XW'(i);
                    lane_y[i] <= '0;
                end
            end else if (capture) begin
                bank_vld <= lane_vld;
                for (int i = 0; i < LANES; i++) begin
                    bank_data[i] <= gen_iter[i*IW +: IW];
                    bank_x[i]    <= lane_x[i];
                    bank_y[i]    <= lane_y[i];
                    lane_x[i]    <= lane_x_nxt[i];
                    lane_y[i]    <= lane_y_nxt[i];
                end
            end
            if (push) bank_vld[sel_idx] <= 1'b0;
        end
    end

    // Serializer: lowest-numbered occupied bank slot goes first, keeping raster order.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (bank_vld[i]) begin
                sel_found = 1'b1;
                sel_idx   = LW'(i);
            end
        end
    end

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign push       = sel_found && !fifo_full;
    assign pop        = out_valid && out_ready;
    assign push_word  = {(bank_x[sel_idx] == xs_q - XW'(1)) && (bank_y[sel_idx] == ys_q - YW'(1)),
                         bank_y[sel_idx], bank_x[sel_idx], bank_data[sel_idx]};

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frame_done <= 1'b0;
        end else if (frame_abort) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            frame_done <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            frame_done <= pop && head[FW-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= push_word;
    end

    assign head      = fifo_mem[rd_ptr];
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? head[IW-1:0] : '0;
    assign out_x     = out_valid ? head[IW +: XW] : '0;
    assign out_y     = out_valid ? head[IW+XW +: YW] : '0;
    assign out_last  = out_valid && head[FW-1];

`ifdef MANDEL_DISPATCH_STATS_EN
    logic [31:0] stat_q;
    logic        stat_run;

    // Counts the accepting cycle through the frame_done cycle; frozen by abort, saturating.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            stat_q   <= '0;
            stat_run <= 1'b0;
        end else if (start_accept) begin
            stat_q   <= 32'd1;
            stat_run <= 1'b1;
        end else if (frame_abort) begin
            stat_run <= 1'b0;
        end else if (stat_run) begin
            if (stat_q != '1) stat_q <= stat_q + 32'd1;
            if (frame_done) stat_run <= 1'b0;
        end
    end

    assign stat_cycles = stat_q;
`else
    assign stat_cycles = 32'd0;
`endif

endmodule

// File: doc/mandelbrot_lane_dispatcher.md
# mandelbrot_lane_dispatcher

Parametrised frame scheduler for the Mandelbrot renderer. It walks a frame in raster order and dispatches pixel coordinates in lockstep batches to `LANES` external point-generator units. It captures their iteration counts and streams them out through a FIFO with a valid/ready handshake, so computing the next batch overlaps with draining the previous one. It sits between the point-generator array and the frame-buffer/VGA write path, replacing the single-batch stop-and-wait render controller.

## Interface
- `LANES`, 4: number of point-generator lanes; 1..16; must be < `x_size`.
- `IW`, 16: iteration-count width.
- `XW`, 11: x coordinate width.
- `YW`, 11: y coordinate width.
- `FIFO_DEPTH`, 16: output FIFO depth; power of 2, >= `LANES`.

Ports:
- `CLK`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high; clock CLK.
- `frame_start`  in  1  pulse; starts a frame when idle.
- `frame_abort`  in  1  pulse; abandons the current frame.
- `x_size`  in  XW  frame width; latched on an accepted `frame_start`.
- `y_size`  in  YW  frame height; latched on an accepted `frame_start`.
- `busy`  out  1  frame in progress.
- `gen_start`  out  1  one-cycle launch pulse to all lanes.
- `gen_x`  out  LANES*XW  per-lane x; lane i occupies bits [i*XW +: XW].
- `gen_y`  out  LANES*YW  per-lane y.
- `gen_valid`  out  LANES  lane holds a real pixel in this batch.
- `gen_done`  in  LANES  level; held high from finish until the next `gen_start`.
- `gen_iter`  in  LANES*IW  per-lane iteration counts.
- `out_valid`  out  1  pixel word available.
- `out_ready`  in  1  consumer accepts.
- `out_data`  out  IW  iteration count.
- `out_x`, `out_y`  out  XW/YW  coordinate of `out_data`.
- `out_last`  out  1  final pixel of the frame.
- `frame_done`  out  1  one-cycle pulse when the `out_last` word is accepted.
- `stat_cycles`  out  32  see Configuration.

## Operation

The dispatch FSM has four states: IDLE, LAUNCH, WAIT, FLUSH.
- **IDLE**: on `frame_start`, latch sizes, reset lane coordinates so lane i is at (i,0), set `busy`, go to LAUNCH.
- **LAUNCH**: assert `gen_start` for one cycle with coordinates and `gen_valid`, then go to WAIT.
- **WAIT**: when every lane with `gen_valid=1` shows `gen_done=1` and the capture bank is empty:
  - capture `gen_iter`, coordinates and `gen_valid` into the bank;
  - advance each lane by `LANES`: x' = x+LANES, or x+LANES−x_size with y+1 on wrap;
  - if the batch held the last pixel, go to FLUSH; otherwise go to LAUNCH.
  - Lanes with `gen_valid=0` are ignored; their `gen_done` is don't-care.
- **FLUSH**: wait until the bank and FIFO are empty and the last word has been accepted, then return to IDLE and clear `busy`.

`gen_valid[i]` is 0 when the lane's y >= y_size, which masks the partial final batch.

The serializer is independent of the FSM. It moves bank entries to the FIFO in lane order, skipping invalid entries, at one per cycle while the FIFO is not full. The bank is "empty" once all its valid entries have moved.

Output rules:
- `out_last` is set on the entry at (x_size−1, y_size−1).
- `out_data`, `out_x`, `out_y` and `out_last` are held stable while `out_valid && !out_ready`.

Boundary behaviour:
- `frame_abort` in any state, including on the same cycle as `frame_start`: abort wins. Go to IDLE, clear `busy`, flush the FIFO and bank, drop `out_valid`, no `frame_done`. Any in-flight lane results are ignored.
- `frame_start` while `busy`: ignored.
- FIFO full: the serializer stalls and the bank stays occupied, which holds the FSM in WAIT. No data is lost.
- `reset` mid-frame: identical to abort, but asynchronous.

## Timing
- All outputs reset to 0; the FSM resets to IDLE.
- `frame_start` sampled at edge N gives `gen_start` high during cycle N+1.
- Lanes complete (capture condition true) at edge K gives the next `gen_start` during cycle K+1.
- Bank capture at edge K gives the first entry written to the FIFO at edge K+1 and `out_valid` high during cycle K+2.
- Sustained throughput is 1 pixel/cycle at the output, limited by lane compute time.
- The FIFO is registered; the output path has no combinational path from `out_ready` to `out_valid`.

## Configuration
- `MANDEL_DISPATCH_STATS_EN` defined:
  - `stat_cycles` counts cycles from the accepted `frame_start` to `frame_done`, inclusive.
  - It holds its value until the next accepted `frame_start` and saturates at 2^32−1.
  - Abort leaves it frozen at its current value.
- Not defined: `stat_cycles` is tied to 0 and no counter logic is generated.

## Test plan
- **Small frame**: LANES=4, 8x2 frame, each lane model returns iter = x+10*y after 5 cycles, `out_ready`=1. Expect 16 words in raster order (0,1,…,7,10,…,17), `out_last` only on (7,1), one `frame_done`, 4 `gen_start` pulses.
- **Partial batch**: 5x1 frame, LANES=4. Expect second batch `gen_valid`=4'b0001, exactly 5 words out, `out_last` on (4,0).
- **Backpressure**: FIFO_DEPTH=4, `out_ready` low for 50 cycles mid-frame. Expect the FSM to hold in WAIT with no `gen_start`, no lost or duplicated words, and output stable while stalled.
- **Abort**: `frame_abort` during the third WAIT. Expect `busy`=0 and `out_valid`=0 the next cycle, no `frame_done`; a following 4x1 frame runs cleanly from (0,0).
- **Simultaneous start/abort**: both high in IDLE. Expect no frame to start and no `gen_start`.
- **Stats**: with `MANDEL_DISPATCH_STATS_EN` and the 8x2 frame above, `stat_cycles` equals the cycle count measured by the bench; without the macro it reads 0.
